// File: rtl/sbqm_pkg.sv
// Shared types and default timing constants for the bank queue manager doorway logic.
package sbqm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EN_O,
        EN_OI,
        EN_I,
        EX_I,
        EX_IO,
        EX_O,
        WAIT_CLR
    } gate_state_t;

    localparam int DEB_CYC_DEF     = 4;
    localparam int TIMEOUT_CYC_DEF = 1000;

endpackage

// File: rtl/sbqm_beam_filter.sv
// One light beam: 2-flop synchroniser, then a debounce that moves the filtered level only
// after DEB_CYC consecutive cycles of disagreement.
module sbqm_beam_filter
    import sbqm_pkg::*;
#(
    parameter int DEB_CYC = DEB_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_filt
);

    localparam int              CW       = $clog2(DEB_CYC + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEB_CYC - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_filt;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_filt  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt >= CNT_LAST) begin
                r_filt <= r_sync2;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/sbqm_gate_decoder.sv
// Doorway decoder: orders the two filtered beams into entry/exit passages and emits one
// registered pulse per completed passage; aborts stuck or ambiguous passages with a fault pulse.
module sbqm_gate_decoder
    import sbqm_pkg::*;
#(
    parameter int DEB_CYC     = DEB_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic beam_out_raw,
    input  logic beam_in_raw,
    output logic sensor_a,
    output logic sensor_b,
    output logic busy,
    output logic fault
);

    localparam int            TW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    gate_state_t   r_state;
    gate_state_t   w_next;
    logic [TW-1:0] r_to_cnt;
    logic          r_sensor_a, r_sensor_b, r_busy, r_fault;
    logic          w_o, w_i, w_active;
    logic          w_a, w_b, w_fault;

    sbqm_beam_filter #(.DEB_CYC(DEB_CYC)) u_filt_out (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (beam_out_raw),
        .o_filt (w_o)
    );

    sbqm_beam_filter #(.DEB_CYC(DEB_CYC)) u_filt_in (
        .clk    (clk),
        .rst    (rst),
        .i_raw  (beam_in_raw),
        .o_filt (w_i)
    );

    assign w_active = (r_state != IDLE) && (r_state != WAIT_CLR);

    always_comb begin
        w_next  = r_state;
        w_a     = 1'b0;
        w_b     = 1'b0;
        w_fault = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_o && !w_i)      w_next = EN_O;
                else if (!w_o && w_i) w_next = EX_I;
                else if (w_o && w_i) begin
                    w_next  = WAIT_CLR;
                    w_fault = 1'b1;
                end
            end
            EN_O: begin
                if (w_o && w_i)        w_next = EN_OI;
                else if (!w_o && !w_i) w_next = IDLE;
            end
            EN_OI: begin
                if (!w_o && w_i)      w_next = EN_I;
                else if (w_o && !w_i) w_next = EN_O;
                else if (!w_o && !w_i) begin
                    w_next  = WAIT_CLR;
                    w_fault = 1'b1;
                end
            end
            EN_I: begin
                if (!w_o && !w_i) begin
                    w_next = IDLE;
                    w_a    = 1'b1;
                end else if (w_o && w_i) w_next = EN_OI;
            end
            EX_I: begin
                if (w_o && w_i)        w_next = EX_IO;
                else if (!w_o && !w_i) w_next = IDLE;
            end
            EX_IO: begin
                if (w_o && !w_i)      w_next = EX_O;
                else if (!w_o && w_i) w_next = EX_I;
                else if (!w_o && !w_i) begin
                    w_next  = WAIT_CLR;
                    w_fault = 1'b1;
                end
            end
            EX_O: begin
                if (!w_o && !w_i) begin
                    w_next = IDLE;
                    w_b    = 1'b1;
                end else if (w_o && w_i) w_next = EX_IO;
            end
            WAIT_CLR: begin
                if (!w_o && !w_i) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        // A stuck passage is abandoned even if it would otherwise complete this cycle.
        if (w_active && (r_to_cnt == TO_LAST)) begin
            w_next  = WAIT_CLR;
            w_a     = 1'b0;
            w_b     = 1'b0;
            w_fault = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_to_cnt   <= '0;
            r_sensor_a <= 1'b0;
            r_sensor_b <= 1'b0;
            r_busy     <= 1'b0;
            r_fault    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_sensor_a <= w_a;
            r_sensor_b <= w_b;
            r_fault    <= w_fault;
            r_busy     <= (w_next != IDLE);
            if (w_next != r_state)
                r_to_cnt <= '0;
            else if (w_active && (r_to_cnt != TO_LAST))
                r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign sensor_a = r_sensor_a;
    assign sensor_b = r_sensor_b;
    assign busy     = r_busy;
    assign fault    = r_fault;

endmodule
